// File: rtl/latch_bank_write_ctrl_pkg.sv
// Shared types, default sizing and helper functions for the latch bank write controller.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    GATE,
    HOLD
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_GATE_CYC = 1;
  localparam int DEF_HOLD_CYC = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/latch_bank_write_ctrl_if.sv
// Requester/latch-bank bus for the write controller; slave is the controller side.
interface latch_bank_write_ctrl_if
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [DEPTH-1:0]          latch_en;
  logic [WIDTH-1:0]          latch_d;
  logic                      busy;

  modport master (
    output req, req_addr, req_data,
    input  gnt, ack, err, latch_en, latch_d, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, ack, err, latch_en, latch_d, busy
  );

endinterface

// File: rtl/latch_bank_write_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo NUM_REQ.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  localparam int unsigned N = NUM_REQ;

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Arbitrates requesters onto a latch bank and sequences each write as setup, gate pulse, hold.
module latch_bank_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GATE_CYC = DEF_GATE_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input logic                   clock,
  input logic                   reset,
  latch_bank_write_ctrl_if.slave bus
);

  localparam int unsigned N     = NUM_REQ;
  localparam int unsigned PTR_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(max2(GATE_CYC, HOLD_CYC) + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [PTR_W-1:0]     ptr;
  logic [ADDR_W-1:0]    addr_q;
  logic                 bad_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 err_q;
  logic [DEPTH-1:0]     en_q;
  logic [WIDTH-1:0]     d_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]     arb_winner;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_bad;
  logic [PTR_W-1:0]     next_ptr;
  logic [DEPTH-1:0]     dec;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .en     (state == IDLE),
    .grant  (arb_grant),
    .winner (arb_winner)
  );

  always_comb begin
    sel_addr = bus.req_addr[arb_winner*ADDR_W +: ADDR_W];
    sel_data = bus.req_data[arb_winner*WIDTH +: WIDTH];
    sel_bad  = (32'(sel_addr) >= 32'(DEPTH));
    next_ptr = PTR_W'((32'(arb_winner) + 1) % N);
  end

  // An out-of-range address matches no bit, so the gate stays low on its own.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < 32'(DEPTH); i++) dec[i] = (32'(addr_q) == i);
  end

  // latch_d only loads on the grant edge, while latch_en is guaranteed low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      addr_q <= '0;
      bad_q  <= 1'b0;
      gnt_q  <= '0;
      ack_q  <= '0;
      err_q  <= 1'b0;
      en_q   <= '0;
      d_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            state  <= SETUP;
            gnt_q  <= arb_grant;
            ptr    <= next_ptr;
            addr_q <= sel_addr;
            bad_q  <= sel_bad;
            d_q    <= sel_data;
            busy_q <= 1'b1;
          end
        end
        SETUP: begin
          state <= GATE;
          cnt   <= CNT_W'(GATE_CYC - 1);
          en_q  <= dec;
        end
        GATE: begin
          if (cnt == '0) begin
            state <= HOLD;
            en_q  <= '0;
            cnt   <= CNT_W'(HOLD_CYC - 1);
            if (HOLD_CYC == 1) begin
              ack_q <= gnt_q;
              err_q <= bad_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              ack_q <= gnt_q;
              err_q <= bad_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.latch_en = en_q;
  assign bus.latch_d  = d_q;
  assign bus.busy     = busy_q;

endmodule
